// File: rtl/a2bus_packet_fifo.sv
// Show-ahead packet FIFO between Apple II bus capture and the serializer.
// Ports: clk_i/rst_n (sync, active-low), wr_i/data_i push side,
//   pkt_valid_o/pkt_data_o/pkt_busy_i head side, full_o, level_o,
//   drop_count_o, overflow_o status. Drop runs are reported in-band
//   by a marker packet {16'hFFFF, run_cnt, 8'h02}.
module a2bus_packet_fifo #(
  parameter bit ENABLE     = 1'b1,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  wr_i,
  input  logic [31:0]           data_i,
  output logic                  pkt_valid_o,
  output logic [31:0]           pkt_data_o,
  input  logic                  pkt_busy_i,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [15:0]           drop_count_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic ST_NORMAL    = 1'b0;
  localparam logic ST_MARK_PEND = 1'b1;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            run_cnt_q, run_cnt_d;
  logic                  state_q, state_d;

  logic                  wr_en;
  logic                  valid;
  logic                  pop;
  logic                  space;
  logic                  push;
  logic                  drop;
  logic [31:0]           push_data;

  assign wr_en = wr_i & ENABLE;
  assign valid = (level_q != '0);
  assign pop   = valid & ~pkt_busy_i;
  // level never exceeds DEPTH, so the MSB alone means full.
  // A same-cycle pop frees the slot the push needs.
  assign space = ~level_q[DEPTH_LOG2] | pop;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    push       = 1'b0;
    drop       = 1'b0;
    push_data  = data_i;

    unique case (state_q)
      ST_NORMAL: begin
        if (wr_en) begin
          if (space) begin
            push = 1'b1;
          end else begin
            drop      = 1'b1;
            state_d   = ST_MARK_PEND;
            run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q
                                             : run_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        if (space) begin
          // Marker takes the slot; a coincident write starts a new run.
          push      = 1'b1;
          push_data = {16'hFFFF, run_cnt_q, 8'h02};
          if (wr_en) begin
            drop      = 1'b1;
            run_cnt_d = 8'd1;
          end else begin
            run_cnt_d = 8'd0;
            state_d   = ST_NORMAL;
          end
        end else if (wr_en) begin
          drop      = 1'b1;
          run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q
                                           : run_cnt_q + 8'd1;
        end
      end
    endcase

    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q
                                            : drop_cnt_q + 16'd1;
    end

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      run_cnt_q  <= '0;
      state_q    <= ST_NORMAL;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      run_cnt_q  <= run_cnt_d;
      state_q    <= state_d;
    end
  end

  // Storage needs no reset; the pointers and level define what is live.
  always_ff @(posedge clk_i) begin
    if (rst_n && push) mem_q[wptr_q] <= push_data;
  end

  assign pkt_valid_o  = ENABLE & valid;
  assign pkt_data_o   = pkt_valid_o ? mem_q[rptr_q] : 32'h0;
  assign full_o       = ENABLE & level_q[DEPTH_LOG2];
  assign level_o      = ENABLE ? level_q : '0;
  assign drop_count_o = ENABLE ? drop_cnt_q : 16'h0;
  assign overflow_o   = ENABLE & ovf_q;

endmodule

// File: tb/tb_a2bus_packet_fifo.sv
// Directed bench for a2bus_packet_fifo with a scoreboard queue of
// expected head packets, compared whenever a pop occurs.
module tb_a2bus_packet_fifo;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        wr_i;
  logic [31:0] data_i;
  logic        pkt_valid_o;
  logic [31:0] pkt_data_o;
  logic        pkt_busy_i;
  logic        full_o;
  logic [4:0]  level_o;
  logic [15:0] drop_count_o;
  logic        overflow_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  a2bus_packet_fifo #(.ENABLE(1'b1), .DEPTH_LOG2(4)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .wr_i         (wr_i),
    .data_i       (data_i),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_data_o   (pkt_data_o),
    .pkt_busy_i   (pkt_busy_i),
    .full_o       (full_o),
    .level_o      (level_o),
    .drop_count_o (drop_count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the head if it pops on the coming edge, then advance.
  task automatic step();
    if (pkt_valid_o && !pkt_busy_i) begin
      if (exp_q.size() == 0)
        chk("unexpected_pop", pkt_data_o, 32'hDEAD_BEEF);
      else
        chk("pop_data", pkt_data_o, exp_q.pop_front());
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_n = 1'b0; wr_i = 1'b0; data_i = '0; pkt_busy_i = 1'b0;
    @(negedge clk_i);
    step();
    rst_n = 1'b1;
    chk("rst_valid", {31'd0, pkt_valid_o}, 32'd0);
    chk("rst_data", pkt_data_o, 32'h0);
    chk("rst_level", {27'd0, level_o}, 32'd0);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_drop", {16'd0, drop_count_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

    // Show-ahead single packet.
    wr_i = 1'b1; data_i = 32'hC030_5580; exp_q.push_back(data_i);
    step();
    wr_i = 1'b0;
    chk("sa_valid", {31'd0, pkt_valid_o}, 32'd1);
    chk("sa_data", pkt_data_o, 32'hC030_5580);
    chk("sa_level1", {27'd0, level_o}, 32'd1);
    step();
    chk("sa_level0", {27'd0, level_o}, 32'd0);
    chk("sa_valid0", {31'd0, pkt_valid_o}, 32'd0);
    chk("sa_data0", pkt_data_o, 32'h0);

    // Fill 16, drop 3.
    pkt_busy_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_i = 1'b1; data_i = 32'h1000_0000 + i;
      exp_q.push_back(data_i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      data_i = 32'h2000_0000 + i;
      step();
    end
    wr_i = 1'b0;
    chk("ovr_full", {31'd0, full_o}, 32'd1);
    chk("ovr_drop", {16'd0, drop_count_o}, 32'd3);
    chk("ovr_ovf", {31'd0, overflow_o}, 32'd1);
    chk("ovr_level", {27'd0, level_o}, 32'd16);

    // One pop frees a slot; the marker fills it.
    pkt_busy_i = 1'b0;
    exp_q.push_back(32'hFFFF_0302);
    step();
    pkt_busy_i = 1'b1;
    chk("mk_level", {27'd0, level_o}, 32'd16);
    chk("mk_full", {31'd0, full_o}, 32'd1);

    // Full, NORMAL, pop with push: accepted.
    pkt_busy_i = 1'b0; wr_i = 1'b1; data_i = 32'hA5A5_0001;
    exp_q.push_back(data_i);
    step();
    wr_i = 1'b0; pkt_busy_i = 1'b1;
    chk("pp_level", {27'd0, level_o}, 32'd16);
    chk("pp_drop", {16'd0, drop_count_o}, 32'd3);

    // Enter MARK_PEND, then write during the marker push.
    wr_i = 1'b1; data_i = 32'h3000_0001;
    step();
    pkt_busy_i = 1'b0; data_i = 32'h3000_0002;
    exp_q.push_back(32'hFFFF_0102);
    step();
    wr_i = 1'b0;
    chk("mp_drop", {16'd0, drop_count_o}, 32'd5);
    chk("mp_level", {27'd0, level_o}, 32'd16);
    exp_q.push_back(32'hFFFF_0102);
    step();
    chk("mp_level2", {27'd0, level_o}, 32'd16);

    // Drain and verify order through the scoreboard.
    for (int i = 0; i < 40 && pkt_valid_o; i++) step();
    chk("drain_level", {27'd0, level_o}, 32'd0);
    chk("drain_sb", exp_q.size(), 32'd0);

    // Reset while full and MARK_PEND, with wr_i high.
    pkt_busy_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_i = 1'b1; data_i = 32'h4000_0000 + i;
      step();
    end
    chk("pre_rst_drop", {16'd0, drop_count_o}, 32'd6);
    rst_n = 1'b0; data_i = 32'h5555_AAAA;
    step();
    rst_n = 1'b1; wr_i = 1'b0;
    chk("mr_level", {27'd0, level_o}, 32'd0);
    chk("mr_valid", {31'd0, pkt_valid_o}, 32'd0);
    chk("mr_drop", {16'd0, drop_count_o}, 32'd0);
    chk("mr_ovf", {31'd0, overflow_o}, 32'd0);
    chk("mr_full", {31'd0, full_o}, 32'd0);
    pkt_busy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_marker", {31'd0, pkt_valid_o}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
